// File: rtl/coef_ram_arbiter.sv
// Two-requester arbiter for a shared synchronous-read coefficient RAM.
// Round-robin on contention, burst lock per owner, idle-timeout release.
//
//   state | meaning
//   IDLE  | no owner, waiting for a request
//   OWN0  | requester 0 owns the RAM port (gnt0=1)
//   OWN1  | requester 1 owns the RAM port (gnt1=1)
module coef_ram_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 16,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              last0,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    // Timeout fires on the idle cycle that would bring the timer to IDLE_TIMEOUT.
    localparam logic [7:0] TIMEOUT_M1 = 8'(IDLE_TIMEOUT - 1);

    state_t            state;
    logic              rr;
    logic [7:0]        lock_timer;
    logic [ADDR_W-1:0] addr_hold;

    logic accept0, accept1;
    logic owner_req, owner_last, other_req;
    logic timer_hit, burst_end;

    assign accept0  = req0 & gnt0;
    assign accept1  = req1 & gnt1;
    assign ram_addr = accept0 ? addr0 : (accept1 ? addr1 : addr_hold);
    assign rdata0   = rvalid0 ? ram_dout : '0;
    assign rdata1   = rvalid1 ? ram_dout : '0;

    always_comb begin
        owner_req  = (state == OWN1) ? req1  : req0;
        owner_last = (state == OWN1) ? last1 : last0;
        other_req  = (state == OWN1) ? req0  : req1;
        timer_hit  = !owner_req && (lock_timer == TIMEOUT_M1);
        burst_end  = (state == OWN0 || state == OWN1) &&
                     (owner_req ? owner_last : timer_hit);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr         <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            lock_timer <= '0;
            addr_hold  <= '0;
        end else begin
            rvalid0 <= accept0;
            rvalid1 <= accept1;
            if (accept0 || accept1)
                addr_hold <= ram_addr;

            case (state)
                IDLE: begin
                    lock_timer <= '0;
                    if (req0 && (!req1 || !rr)) begin
                        state <= OWN0;
                        gnt0  <= 1'b1;
                    end else if (req1) begin
                        state <= OWN1;
                        gnt1  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (burst_end) begin
                        rr         <= (state == OWN0);
                        lock_timer <= '0;
                        if (other_req) begin
                            // Hand straight over to the waiting requester, no idle bubble.
                            state <= (state == OWN0) ? OWN1 : OWN0;
                            gnt0  <= (state == OWN1);
                            gnt1  <= (state == OWN0);
                        end else begin
                            state <= IDLE;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                        end
                    end else if (owner_req) begin
                        lock_timer <= '0;
                    end else if (lock_timer != 8'hFF) begin
                        lock_timer <= lock_timer + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coef_ram_arbiter.sv
// Bench for coef_ram_arbiter: directed scenarios plus random traffic,
// compared each cycle against a behavioural arbitration model.
module tb_coef_ram_arbiter;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0, req1, last0, last1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1, ram_dout;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] mem [2**AW];

    coef_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IDLE_TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) ram_dout <= mem[ram_addr];

    int total = 0;
    int bad = 0;

    // model: owner -1 = nobody, else requester index
    int            m_owner, m_rr, m_cnt;
    logic [AW-1:0] m_hold;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;
    bit            s_gnt1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_cnt = 0; m_hold = '0;
        m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
    endtask

    task automatic check_outputs(input logic [AW-1:0] exp_addr);
        chk("gnt0", 32'(gnt0), 32'(m_owner == 0));
        chk("gnt1", 32'(gnt1), 32'(m_owner == 1));
        chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
        chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
        chk("rdata0", 32'(rdata0), 32'(m_rd0));
        chk("rdata1", 32'(rdata1), 32'(m_rd1));
        chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    endtask

    // One clock: drive, check, advance model, step to the next falling edge.
    task automatic cyc(input bit r0, input logic [AW-1:0] a0, input bit l0,
                       input bit r1, input logic [AW-1:0] a1, input bit l1);
        bit acc0, acc1, ro, lo, rx, fin;
        int o;
        logic [AW-1:0] exp_addr;
        req0 = r0; addr0 = a0; last0 = l0;
        req1 = r1; addr1 = a1; last1 = l1;
        #1;
        acc0 = (m_owner == 0) && r0;
        acc1 = (m_owner == 1) && r1;
        exp_addr = acc0 ? a0 : (acc1 ? a1 : m_hold);
        check_outputs(exp_addr);
        s_gnt1 = gnt1;
        m_rv0 = acc0; m_rd0 = acc0 ? mem[a0] : '0;
        m_rv1 = acc1; m_rd1 = acc1 ? mem[a1] : '0;
        m_hold = exp_addr;
        if (m_owner < 0) begin
            if (r0 && r1) m_owner = m_rr;
            else if (r0) m_owner = 0;
            else if (r1) m_owner = 1;
        end else begin
            o = m_owner;
            ro = (o == 1) ? r1 : r0;
            lo = (o == 1) ? l1 : l0;
            rx = (o == 1) ? r0 : r1;
            fin = 0;
            if (ro) begin
                m_cnt = 0;
                fin = lo;
            end else begin
                m_cnt++;
                if (m_cnt >= TO) begin fin = 1; m_cnt = 0; end
            end
            if (fin) begin
                m_rr = 1 - o;
                m_owner = rx ? 1 - o : -1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        #1;
        model_reset();
        check_outputs('0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int k, guard, held;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        reset_n = 1'b0;
        req0 = 0; req1 = 0; last0 = 0; last1 = 0; addr0 = '0; addr1 = '0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_outputs('0);
        reset_n = 1'b1;

        // single requester, addresses 0..63
        k = 0; guard = 0;
        while (k < 64 && guard < 200) begin
            guard++;
            if (m_owner == 0) begin
                cyc(1, AW'(k), k == 63, 0, '0, 0);
                k++;
            end else begin
                cyc(1, AW'(k), k == 63, 0, '0, 0);
            end
        end
        chk("burst0_done", 32'(k), 32'd64);
        cyc(0, '0, 0, 0, '0, 0);
        cyc(0, '0, 0, 0, '0, 0);

        // simultaneous start, req1 waits for the whole burst of 0
        do_reset();
        k = 0; guard = 0;
        while (k < 64 && guard < 200) begin
            guard++;
            if (m_owner == 0) begin
                cyc(1, AW'($urandom), k == 63, 1, AW'($urandom), 0);
                k++;
            end else begin
                cyc(1, AW'($urandom), 0, 1, AW'($urandom), 0);
            end
        end
        chk("burst0b_done", 32'(k), 32'd64);

        // owner 1 reads 5 words, then goes quiet while req0 waits
        for (int j = 0; j < 5; j++) cyc(1, AW'($urandom), 0, 1, AW'($urandom), 0);
        held = 0;
        for (int j = 0; j < 20; j++) begin
            cyc(1, AW'($urandom), 0, 0, '0, 0);
            if (s_gnt1) held++;
        end
        chk("lock_hold", 32'(held), 32'(TO));
        cyc(1, AW'($urandom), 1, 0, '0, 0);
        cyc(0, '0, 0, 0, '0, 0);

        // reset on the cycle of an accept
        for (int j = 0; j < 4; j++) cyc(1, AW'($urandom), 0, 0, '0, 0);
        req0 = 1; addr0 = 7'd42; last0 = 0;
        #1;
        chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        req0 = 0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) cyc(0, '0, 0, 0, '0, 0);

        // single-read bursts from both sides
        do_reset();
        for (int j = 0; j < 12; j++) cyc(1, AW'($urandom), 1, 1, AW'($urandom), 1);
        cyc(0, '0, 0, 0, '0, 0);

        // random traffic with varying request density
        for (int seg = 0; seg < 8; seg++) begin
            int pr, pl;
            pr = $urandom_range(20, 95);
            pl = $urandom_range(3, 40);
            for (int j = 0; j < 250; j++)
                cyc($urandom_range(0, 99) < pr, AW'($urandom), $urandom_range(0, 99) < pl,
                    $urandom_range(0, 99) < pr, AW'($urandom), $urandom_range(0, 99) < pl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coef_ram_arbiter.md
COEF_RAM_ARBITER -- requirements
Module: coef_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, coefficient RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, coefficient word width.
REQ-003 The block SHALL have parameter IDLE_TIMEOUT, default 16, idle cycles after which a locked owner loses the grant (range 1..255).
REQ-004 clock  input  1  single clock for the whole block (audio BIT_CLK domain, 12.288 MHz).
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 req0, req1  input  1 each  requester N wants to issue a RAM read this cycle.
REQ-007 addr0, addr1  input  ADDR_W each  read address from requester N, valid while reqN=1.
REQ-008 last0, last1  input  1 each  current read is the final read of requester N's burst.
REQ-009 gnt0, gnt1  output  1 each  requester N owns the RAM port; registered, never both 1.
REQ-010 rvalid0, rvalid1  output  1 each  rdataN carries the word for the read accepted one cycle earlier.
REQ-011 rdata0, rdata1  output  DATA_W each  read data to requester N.
REQ-012 ram_addr  output  ADDR_W  address to the RAM read port (synchronous read, 1-cycle latency).
REQ-013 ram_dout  input  DATA_W  RAM read data, valid the cycle after ram_addr is presented.

Function
REQ-014 The FSM SHALL have states IDLE, OWN0, OWN1; gntN SHALL be 1 exactly when the state is OWNN.
REQ-015 A read SHALL be accepted in any cycle where reqN=1 and gntN=1; no other cycle accepts a read.
REQ-016 On an accept, ram_addr SHALL equal addrN combinationally in that cycle; in cycles without an accept, ram_addr SHALL hold its last accepted value (0 after reset).
REQ-017 rvalidN SHALL be a register set to 1 the cycle after an accept by N and 0 otherwise; rdataN SHALL equal ram_dout when rvalidN=1 and 0 otherwise.
REQ-018 Read latency SHALL be exactly 1 cycle from accept to rvalid; back-to-back accepts SHALL sustain one read per cycle.
REQ-019 IDLE: if exactly one reqN=1, next state SHALL be OWNN; if both, next state SHALL be OWN of the requester indicated by a 1-bit round-robin pointer rr; if none, stay IDLE.
REQ-020 OWNN: an accept with lastN=1 SHALL end the burst; the next state SHALL be OWN of the other requester if its req=1 that cycle (no idle bubble), else IDLE.
REQ-021 On every burst end (last or timeout), rr SHALL point to the other requester.
REQ-022 OWNN with reqN=0 SHALL keep the grant (burst lock) and increment a lock timer; any cycle with reqN=1 SHALL clear the timer.
REQ-023 When the lock timer reaches IDLE_TIMEOUT, the burst SHALL end as in REQ-020 without an accept, and the timer SHALL clear.
REQ-024 A req from the non-owner SHALL never pre-empt an active burst; it is only served after that burst ends.
REQ-025 A single-read burst (req and last both 1 in the first granted cycle) SHALL be legal.
REQ-026 The timer SHALL be 8 bits wide and SHALL saturate, never wrapping.

Reset
REQ-027 While reset_n=0: state IDLE, rr=0 (requester 0 favoured), gnt0=gnt1=0, rvalid0=rvalid1=0, ram_addr=0, timer=0, all asynchronously.
REQ-028 Reset asserted mid-burst SHALL discard the in-flight read (no rvalid after release); after release the FSM starts from IDLE.

Verification
REQ-029 Single requester: req0=1 with addr 0..63, last0 on addr 63 -> gnt0 rises 1 cycle after req0; 64 consecutive rvalid0 pulses carry RAM words 0..63 in order; IDLE afterwards.
REQ-030 Simultaneous start after reset: req0=req1=1 -> OWN0 first (rr=0); 64-read burst; gnt1 rises the cycle after last0 accept, no gap; rr=1 after.
REQ-031 Lock/timeout: grant to 1, req1 dropped after 5 reads, no last -> gnt1 held 16 cycles, then released; pending req0 is granted the next cycle.
REQ-032 No pre-emption: req1 asserted during burst of 0 -> gnt1=0 and rvalid1=0 until last0 accepted; gnt0 and gnt1 never both 1.
REQ-033 Reset mid-burst: reset_n low on the cycle of an accept -> gnt, rvalid, ram_addr immediately 0; no rvalid after release.
REQ-034 Single-read bursts alternating: req0, req1 constantly high with last=1 -> grants alternate 0,1,0,1 every cycle, one rvalid per cycle.
